rob_param: RTL
==============

Name: rob_param

Overview:
- Parametrised reorder buffer for the Tomasulo core; successor to the fixed order-manager ROB.
- Allocates entries in program order at issue and captures results from NUM_CDB common-data-bus channels (adders, multipliers, load/store).
- Retires one entry per cycle in order onto the register-file commit bus.
- Adds operand lookup with CDB bypass, entries without a destination, synchronous flush and an occupancy count.

Parameters:
DEPTH, 8, entry count; power of 2, >=2; TAG_W = clog2(DEPTH) (localparam)
DATA_W, 32, result/commit data width
REG_AW, 5, architectural register index width
NUM_CDB, 6, CDB channel count (3 add, 2 mul, 1 LS)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous reset, active-high (1 = reset) despite the name
flush  in  1  synchronous flush of all entries
alloc_valid  in  1  issue request
alloc_has_rd  in  1  entry writes a register
alloc_rd  in  REG_AW  destination register
alloc_ready  out  1  ROB not full
alloc_tag  out  TAG_W  tag given to the request (= tail pointer)
cdb_valid  in  NUM_CDB  per-channel result valid
cdb_tag  in  NUM_CDB*TAG_W  per-channel tags, channel i at [i*TAG_W +: TAG_W]
cdb_data  in  NUM_CDB*DATA_W  per-channel data, same packing
lk_tag_j, lk_tag_k  in  TAG_W  operand lookup tags
lk_ready_j, lk_ready_k  out  1  result available
lk_data_j, lk_data_k  out  DATA_W  result value
commit_valid  out  1  entry retired this cycle
commit_wen  out  1  register write enable
commit_idx  out  REG_AW  register index
commit_data  out  DATA_W  register data
commit_tag  out  TAG_W  retired tag
count  out  TAG_W+1  occupied entries

Behaviour:
- Entry state: busy, done, has_rd, rd, data. Circular head/tail pointers of TAG_W bits wrap DEPTH-1 -> 0; count disambiguates full/empty.
- Reset: all entries clear; head = tail = 0; count = 0; commit_* = 0; alloc_ready = 1; alloc_tag = 0.
- Allocation:
  - alloc_ready = (count != DEPTH), computed from registered count only.
  - When full, a same-cycle commit does not admit an allocation.
  - Accept on alloc_valid && alloc_ready: entry[tail] becomes busy=1, done=0, and tail advances. alloc_tag is combinational.
- CDB capture, per channel:
  - Channel i with cdb_valid[i] writes data to entry[tag] and sets done, only if that entry is busy && !done.
  - Writes to non-busy or already-done entries are ignored.
  - Same tag on several channels: lowest channel index wins.
  - Writes into the entry being allocated in the same cycle are ignored.
- Commit:
  - At each edge, if entry[head] is busy && done: for one cycle (registered outputs, visible after the edge) commit_valid=1, commit_wen=has_rd, commit_idx=rd, commit_data=data, commit_tag=head. The entry is freed and head advances.
  - Otherwise commit_valid=commit_wen=0; idx/data/tag hold their last values.
  - A result captured at edge N commits at edge N+1 at the earliest (1 cycle latency CDB->commit). Maximum one commit per cycle.
- count: next = count + accepted_alloc - commit. Simultaneous alloc and commit leaves it unchanged.
- Lookup (combinational), per port:
  - ready=1, data=entry.data if entry busy && done.
  - Else ready=1, data=CDB data if a CDB channel matches that tag this cycle (lowest index wins, same filter as capture).
  - Else ready=0, data=0.
- Flush:
  - Clears busy/done on all entries; head = tail = 0; count = 0; commit outputs forced 0 on the next cycle.
  - Same-cycle alloc, CDB writes and commit are discarded.
  - Flush has priority over everything but reset.
- Reset mid-operation: immediate return to the reset state, in-flight entries lost.

Test Plan:
- Reset, then 3 allocs (rd=1,2,3); CDB returns tag2=0x30, tag0=0x10, tag1=0x20 over three cycles -> commits in order: idx1/0x10, idx2/0x20, idx3/0x30, with commit_tag 0,1,2. count peaks at 3 and returns to 0.
- Allocate 8 with DEPTH=8 -> alloc_ready=0 and count=8. A 9th alloc_valid held through a cycle where tag0 commits -> not accepted that cycle, accepted next cycle with alloc_tag=0 (wrap).
- Channels 1 and 4 both drive tag 3 (0xAA, 0xBB) -> entry 3 data=0xAA. lk_tag_j=3 in that same cycle -> lk_ready_j=1, lk_data_j=0xAA via bypass.
- Entry with alloc_has_rd=0 completes -> commit_valid=1, commit_wen=0.
- 4 entries busy, flush asserted with concurrent alloc and CDB -> next cycle count=0, alloc_tag=0, no commit_valid. A later CDB to old tags is ignored.
- Assert rst_n=1 mid-stream between edges -> outputs go to reset values immediately, without a clock.

Source files
------------

// File: rtl/rob_param.sv
// Parametrised reorder buffer: in-order allocate, multi-channel CDB capture, in-order retire.
// Operand lookup bypasses results that are on the CDB in the current cycle.
module rob_param #(
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned REG_AW  = 5,
  parameter int unsigned NUM_CDB = 6,
  localparam int unsigned TAG_W  = $clog2(DEPTH)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic                      alloc_valid,
  input  logic                      alloc_has_rd,
  input  logic [REG_AW-1:0]         alloc_rd,
  output logic                      alloc_ready,
  output logic [TAG_W-1:0]          alloc_tag,
  input  logic [NUM_CDB-1:0]        cdb_valid,
  input  logic [NUM_CDB*TAG_W-1:0]  cdb_tag,
  input  logic [NUM_CDB*DATA_W-1:0] cdb_data,
  input  logic [TAG_W-1:0]          lk_tag_j,
  input  logic [TAG_W-1:0]          lk_tag_k,
  output logic                      lk_ready_j,
  output logic                      lk_ready_k,
  output logic [DATA_W-1:0]         lk_data_j,
  output logic [DATA_W-1:0]         lk_data_k,
  output logic                      commit_valid,
  output logic                      commit_wen,
  output logic [REG_AW-1:0]         commit_idx,
  output logic [DATA_W-1:0]         commit_data,
  output logic [TAG_W-1:0]          commit_tag,
  output logic [TAG_W:0]            count
);

  localparam int unsigned CNT_W = TAG_W + 1;

  logic [DEPTH-1:0]  busy_q, done_q, has_rd_q;
  logic [REG_AW-1:0] rd_q   [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [TAG_W-1:0]  head_q, tail_q;
  logic [CNT_W-1:0]  count_q;

  logic              commit_valid_q, commit_wen_q;
  logic [REG_AW-1:0] commit_idx_q;
  logic [DATA_W-1:0] commit_data_q;
  logic [TAG_W-1:0]  commit_tag_q;

  logic [DEPTH-1:0]  hit, cap;
  logic [DATA_W-1:0] hit_data [DEPTH];
  logic              alloc_fire, commit_fire;

  assign alloc_ready = (count_q != CNT_W'(DEPTH));
  assign alloc_tag   = tail_q;
  assign alloc_fire  = alloc_valid && alloc_ready && !flush;
  assign commit_fire = busy_q[head_q] && done_q[head_q] && !flush;

  // Scan channels high to low so the lowest-index match is the one left standing.
  always_comb begin
    hit = '0;
    for (int e = 0; e < int'(DEPTH); e++) hit_data[e] = '0;
    for (int i = int'(NUM_CDB) - 1; i >= 0; i--) begin
      for (int e = 0; e < int'(DEPTH); e++) begin
        if (cdb_valid[i] && (cdb_tag[i*TAG_W +: TAG_W] == TAG_W'(e))) begin
          hit[e]      = 1'b1;
          hit_data[e] = cdb_data[i*DATA_W +: DATA_W];
        end
      end
    end
  end

  // The tail entry is never busy while being allocated, so this also drops writes into it.
  assign cap = hit & busy_q & ~done_q;

  always_comb begin
    lk_ready_j = 1'b0;
    lk_data_j  = '0;
    if (busy_q[lk_tag_j] && done_q[lk_tag_j]) begin
      lk_ready_j = 1'b1;
      lk_data_j  = data_q[lk_tag_j];
    end else if (cap[lk_tag_j]) begin
      lk_ready_j = 1'b1;
      lk_data_j  = hit_data[lk_tag_j];
    end
  end

  always_comb begin
    lk_ready_k = 1'b0;
    lk_data_k  = '0;
    if (busy_q[lk_tag_k] && done_q[lk_tag_k]) begin
      lk_ready_k = 1'b1;
      lk_data_k  = data_q[lk_tag_k];
    end else if (cap[lk_tag_k]) begin
      lk_ready_k = 1'b1;
      lk_data_k  = hit_data[lk_tag_k];
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      busy_q         <= '0;
      done_q         <= '0;
      has_rd_q       <= '0;
      for (int e = 0; e < int'(DEPTH); e++) begin
        rd_q[e]   <= '0;
        data_q[e] <= '0;
      end
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      commit_valid_q <= 1'b0;
      commit_wen_q   <= 1'b0;
      commit_idx_q   <= '0;
      commit_data_q  <= '0;
      commit_tag_q   <= '0;
    end else if (flush) begin
      busy_q         <= '0;
      done_q         <= '0;
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      commit_valid_q <= 1'b0;
      commit_wen_q   <= 1'b0;
      commit_idx_q   <= '0;
      commit_data_q  <= '0;
      commit_tag_q   <= '0;
    end else begin
      for (int e = 0; e < int'(DEPTH); e++) begin
        if (cap[e]) begin
          done_q[e] <= 1'b1;
          data_q[e] <= hit_data[e];
        end
      end
      if (commit_fire) begin
        busy_q[head_q] <= 1'b0;
        done_q[head_q] <= 1'b0;
        commit_valid_q <= 1'b1;
        commit_wen_q   <= has_rd_q[head_q];
        commit_idx_q   <= rd_q[head_q];
        commit_data_q  <= data_q[head_q];
        commit_tag_q   <= head_q;
        head_q         <= head_q + TAG_W'(1);
      end else begin
        commit_valid_q <= 1'b0;
        commit_wen_q   <= 1'b0;
      end
      if (alloc_fire) begin
        busy_q[tail_q]   <= 1'b1;
        done_q[tail_q]   <= 1'b0;
        has_rd_q[tail_q] <= alloc_has_rd;
        rd_q[tail_q]     <= alloc_rd;
        tail_q           <= tail_q + TAG_W'(1);
      end
      count_q <= count_q + CNT_W'(alloc_fire) - CNT_W'(commit_fire);
    end
  end

  assign commit_valid = commit_valid_q;
  assign commit_wen   = commit_wen_q;
  assign commit_idx   = commit_idx_q;
  assign commit_data  = commit_data_q;
  assign commit_tag   = commit_tag_q;
  assign count        = count_q;

endmodule
